// File: rtl/step_ctrl.sv
// Run/step sequencing controller: turns divider ticks or debounced button presses
// into single-cycle step_en pulses, with PC breakpoint halt.
module step_ctrl #(
  parameter logic [31:0] DBNC_CYCLES = 32'd1_000_000,
  parameter int          ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic              run_sw,
  input  logic              step_btn,
  input  logic              bp_en,
  input  logic [ADDR_W-1:0] bp_addr,
  input  logic [ADDR_W-1:0] pc,
  output logic              step_en,
  output logic [1:0]        state,
  output logic              halted,
  output logic [15:0]       step_cnt
);

  // state | meaning
  // PAUSE | idle; a debounced press issues one step, ticks ignored
  // RUN   | each tick issues one step unless the breakpoint PC matches
  // HALT  | breakpoint hit; waits for run_sw to drop
  localparam logic [1:0] ST_PAUSE = 2'b00;
  localparam logic [1:0] ST_RUN   = 2'b01;
  localparam logic [1:0] ST_HALT  = 2'b10;

  logic        run_s1, run_s2;
  logic        btn_s1, btn_s2;
  logic        btn_lvl, btn_lvl_q, press;
  logic [31:0] dbnc_cnt;
  logic [31:0] dbnc_nxt;
  logic        bp_hit;
  logic [1:0]  state_nxt;
  logic        step_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_s1 <= 1'b0;
      run_s2 <= 1'b0;
      btn_s1 <= 1'b0;
      btn_s2 <= 1'b0;
    end else begin
      run_s1 <= run_sw;
      run_s2 <= run_s1;
      btn_s1 <= step_btn;
      btn_s2 <= btn_s1;
    end
  end

  assign dbnc_nxt = dbnc_cnt + 32'd1;

  // Press is registered once more so a press lands exactly DBNC_CYCLES+3 edges after the raw input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dbnc_cnt  <= '0;
      btn_lvl   <= 1'b0;
      btn_lvl_q <= 1'b0;
      press     <= 1'b0;
    end else begin
      btn_lvl_q <= btn_lvl;
      press     <= btn_lvl & ~btn_lvl_q;
      if (btn_s2 == btn_lvl) begin
        dbnc_cnt <= '0;
      end else if (dbnc_nxt >= DBNC_CYCLES) begin
        btn_lvl  <= btn_s2;
        dbnc_cnt <= '0;
      end else begin
        dbnc_cnt <= dbnc_nxt;
      end
    end
  end

  assign bp_hit = bp_en && (pc == bp_addr);

  always_comb begin
    state_nxt = state;
    step_nxt  = 1'b0;
    case (state)
      ST_PAUSE: begin
        step_nxt = press;
        if (run_s2) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        // Leaving RUN wins over a same-cycle tick.
        if (!run_s2) begin
          state_nxt = ST_PAUSE;
        end else if (tick) begin
          if (bp_hit) state_nxt = ST_HALT;
          else        step_nxt  = 1'b1;
        end
      end
      ST_HALT: begin
        if (!run_s2) state_nxt = ST_PAUSE;
      end
      default: state_nxt = ST_PAUSE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_PAUSE;
      halted   <= 1'b0;
      step_en  <= 1'b0;
      step_cnt <= '0;
    end else begin
      state    <= state_nxt;
      halted   <= (state_nxt == ST_HALT);
      step_en  <= step_nxt;
      step_cnt <= step_cnt + {15'd0, step_en};
    end
  end

endmodule

// File: doc/step_ctrl.md
# step_ctrl

Run/step sequencing controller for the lab CPU's board harness. It turns the periodic one-cycle tick from the 1 Hz divider into single-cycle `step_en` pulses that advance the datapath. It supports three modes: free-running on the tick, manual single-step from a push-button, and halt on a PC breakpoint. It sits between the tick divider, the board switches/buttons and the CPU's PC/register-write enables.

## Interface
- `DBNC_CYCLES`, default 32'd1_000_000: consecutive stable cycles required to accept a button level change (10 ms at 100 MHz).
- `ADDR_W`, default 32: width of `pc` and `bp_addr`.
- `clk`  input  1  system clock; all logic on rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `tick`  input  1  one-cycle pulse from the tick divider; may be asserted on back-to-back cycles.
- `run_sw`  input  1  raw board switch; 1 = run, 0 = pause.
- `step_btn`  input  1  raw board push-button; bouncy, asynchronous.
- `bp_en`  input  1  breakpoint enable (synchronous, static).
- `bp_addr`  input  ADDR_W  breakpoint PC value.
- `pc`  input  ADDR_W  current CPU PC (synchronous to `clk`).
- `step_en`  output  1  one-cycle advance pulse to the datapath.
- `state`  output  2  current mode: 2'b00 PAUSE, 2'b01 RUN, 2'b10 HALT.
- `halted`  output  1  high while in HALT.
- `step_cnt`  output  16  number of `step_en` pulses issued since reset.

## Operation
- Input conditioning:
  - `run_sw` and `step_btn` each pass through a 2-FF synchronizer.
  - Synced `step_btn` feeds a debouncer. A counter runs while the synced value differs from the debounced level and clears when they match. When the counter reaches `DBNC_CYCLES`, the debounced level takes the synced value and the counter clears.
  - A press is the rising edge of the debounced level: one pulse per press. Release produces no press.
- FSM, reset state PAUSE:
  - PAUSE:
    - A press generates one step. No breakpoint check applies, so a breakpoint can be stepped past.
    - `tick` is ignored.
    - Synced `run_sw`=1 → RUN.
  - RUN:
    - On `tick`, if `bp_en` and `pc`==`bp_addr` in that cycle → HALT with no step. Otherwise, generate one step.
    - Presses are ignored.
    - Synced `run_sw`=0 → PAUSE. This takes priority over a same-cycle `tick`: no step.
  - HALT:
    - No steps; `tick` and presses are ignored.
    - Synced `run_sw`=0 → PAUSE. `run_sw` staying high keeps HALT.
- `step_cnt` increments by 1 per `step_en` and wraps from 16'hFFFF to 16'h0000.
- Debounce state and synchronizers keep running in every FSM state. A press whose debounced rising edge occurs in RUN or HALT is discarded, never queued.

## Timing
- Reset (async assert, any time):
  - `step_en`=0, `state`=2'b00, `halted`=0, `step_cnt`=0.
  - Synchronizer flops, debounced level and debounce counter all go to 0.
  - Reset mid-debounce discards the pending press.
- All outputs are registered. `state`/`halted` change on the edge after the triggering condition is sampled.
- Tick path: `tick` sampled high at edge T (in RUN, no breakpoint hit) → `step_en`=1 during the cycle following edge T, for exactly 1 cycle. `step_cnt` shows the incremented value at edge T+1.
- Back-to-back ticks in RUN give back-to-back `step_en` pulses.
- Breakpoint: `pc` and `bp_addr` are compared combinationally at edge T. On a hit, `state`=HALT and `halted`=1 from edge T, and `step_en` stays 0.
- Switch path: `run_sw` change at raw input → synced 2 edges later → `state` updates on the next edge (3 edges total).
- Button path: `step_btn` first sampled high at edge N and held stable → `step_en`=1 during the cycle after edge N+DBNC_CYCLES+3. Bounces shorter than `DBNC_CYCLES` produce no pulse.
- `step_en` is never high for 2 consecutive cycles from a single press.

## Test plan
- Reset/idle: assert `rst` mid-run; hold `tick` periodic, `run_sw`=0. Required: all outputs 0 and `state`=00 immediately; no `step_en` for 100 cycles.
- Free run: `DBNC_CYCLES`=4, `run_sw`=1, 5 ticks spaced 10 cycles apart plus 2 back-to-back. Required: `state`=01 after 3 edges; 7 `step_en` pulses, each 1 cycle after its tick; `step_cnt`=7.
- Breakpoint: `bp_en`=1, `bp_addr`=32'h0000_0010, `pc` stepping 0,4,8,C,10 on each `step_en`. Required: 4 steps, then HALT with `halted`=1 and `step_cnt`=4. After `run_sw`=0: `state`=00 after 3 edges. One press then steps past 0x10 (`step_cnt`=5).
- Debounce: `DBNC_CYCLES`=4, `run_sw`=0; `step_btn` toggles every 2 cycles for 20 cycles, then held high for 20. Required: exactly 1 `step_en`, at edge N+7 where N is the first edge of the stable level.
- Press in RUN ignored: clean press while `state`=01 with no tick. Required: no `step_en`. Switching to PAUSE afterward does not replay the press.
- Simultaneous/wrap: `tick` in the same cycle that synced `run_sw` falls → no step, `state`=00. Preload 65535 steps → the next step gives `step_cnt`=0.
